div32_iter: RTL and testbench

Iterative 32-bit radix-2 restoring divider for the EX stage; it executes MIPS DIV/DIVU and writes quotient/remainder toward HI/LO. Each iteration uses one 33-bit trial subtraction built from two chained 16-bit carry-lookahead adders (a 32-bit plus a top-bit carry, with b inverted and cin=1). The pipeline stalls on `busy` and consumes the one-cycle `ready` pulse.

---
 rtl/div32_iter.sv | 227 ++++++++++++++++++++++
 tb/tb_div32_iter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/div32_iter.sv
// div32_iter: iterative 32-bit radix-2 restoring divider for MIPS DIV/DIVU.
//
// One quotient bit is produced per cycle from a 33-bit trial subtraction
// built out of two chained 16-bit carry-lookahead adders. Operands are
// reduced to magnitudes when signed, and signs are restored in FIX.
//
// Ports:
//   clk          rising-edge clock
//   resetn       asynchronous active-low reset
//   start        request, sampled only in IDLE or DONE
//   signed_div   1 = DIV (two's complement), 0 = DIVU; latched with start
//   dividend     32-bit dividend, latched with start
//   divisor      32-bit divisor, latched with start
//   annul        abort; overrides everything except reset
//   busy         high in CALC and FIX
//   ready        one-cycle result-valid pulse (DONE)
//   quotient     registered quotient, held until the next result write
//   remainder    registered remainder, held until the next result write
//   div_by_zero  registered flag for the last result

// cla16: 16-bit carry-lookahead adder, four 4-bit groups with a second
// level of lookahead across the groups.
//
// Ports:
//   a, b   addends
//   cin    carry in
//   sum    a + b + cin (low 16 bits)
//   cout   carry out of bit 15
module cla16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  gg;
  logic [3:0]  pp;
  logic [4:0]  cg;

  // carries into bits 1..3 of a 4-bit group, returned as {c3, c2, c1}
  function automatic logic [2:0] inner3(input logic [3:0] gi,
                                        input logic [3:0] pi,
                                        input logic       c0);
    logic [2:0] cc;
    cc[0] = gi[0] | (pi[0] & c0);
    cc[1] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & c0);
    cc[2] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0])
          | (pi[2] & pi[1] & pi[0] & c0);
    return cc;
  endfunction

  assign g = a & b;
  assign p = a ^ b;

  for (genvar j = 0; j < 4; j++) begin : g_grp
    assign gg[j] = g[4*j+3]
                 | (p[4*j+3] & g[4*j+2])
                 | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                 | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
    assign pp[j] = &p[4*j +: 4];
    assign c[4*j] = cg[j];
    assign c[4*j+1 +: 3] = inner3(g[4*j +: 4], p[4*j +: 4], cg[j]);
  end

  // second-level lookahead: carries into each group
  assign cg[0] = cin;
  assign cg[1] = gg[0] | (pp[0] & cin);
  assign cg[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & cin);
  assign cg[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
               | (pp[2] & pp[1] & pp[0] & cin);
  assign cg[4] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
               | (pp[3] & pp[2] & pp[1] & gg[0])
               | (pp[3] & pp[2] & pp[1] & pp[0] & cin);

  assign sum  = p ^ c;
  assign cout = cg[4];

endmodule

// div32_iter top. State table:
//   state | meaning
//   IDLE  | waiting for start
//   CALC  | 32 restoring iterations, one quotient bit per cycle
//   FIX   | apply signs, write quotient/remainder
//   DONE  | ready pulse; a new start may be accepted here
module div32_iter (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        signed_div,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        annul,
  output logic        busy,
  output logic        ready,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  logic [4:0]  count;
  logic [31:0] r;
  logic [31:0] q;
  logic [31:0] dmag;
  logic        sign_q;
  logic        sign_r;

  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] shifted;
  logic [15:0] diff_lo;
  logic [15:0] diff_hi;
  logic        c16;
  logic        c32;
  logic        no_borrow;

  // magnitudes of the incoming operands; 0x80000000 stays 0x80000000
  assign a_mag = (signed_div && dividend[31]) ? (~dividend + 32'd1) : dividend;
  assign b_mag = (signed_div && divisor[31])  ? (~divisor + 32'd1)  : divisor;

  // low 32 bits of {R, Q[31]}; R[31] is the 33rd bit of the trial value
  assign shifted = {r[30:0], q[31]};

  cla16 u_sub_lo (
    .a    (shifted[15:0]),
    .b    (~dmag[15:0]),
    .cin  (1'b1),
    .sum  (diff_lo),
    .cout (c16)
  );

  cla16 u_sub_hi (
    .a    (shifted[31:16]),
    .b    (~dmag[31:16]),
    .cin  (c16),
    .sum  (diff_hi),
    .cout (c32)
  );

  // top bit: R[31] + 1 (inverted zero) + c32; its carry out is the no-borrow flag.
  // When it is set the 33-bit difference is below the divisor, so bit 32 is 0.
  assign no_borrow = r[31] | c32;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      busy        <= 1'b0;
      ready       <= 1'b0;
      quotient    <= 32'd0;
      remainder   <= 32'd0;
      div_by_zero <= 1'b0;
      count       <= 5'd0;
      r           <= 32'd0;
      q           <= 32'd0;
      dmag        <= 32'd0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
    end else if (annul) begin
      state <= IDLE;
      busy  <= 1'b0;
      ready <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          ready <= 1'b0;
          if (start) begin
            sign_q <= signed_div & (dividend[31] ^ divisor[31]);
            sign_r <= signed_div & dividend[31];
            dmag   <= b_mag;
            if (divisor == 32'd0) begin
              state       <= DONE;
              ready       <= 1'b1;
              quotient    <= 32'd0;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= CALC;
              busy  <= 1'b1;
              count <= 5'd0;
              r     <= 32'd0;
              q     <= a_mag;
            end
          end
        end

        CALC: begin
          r     <= no_borrow ? {diff_hi, diff_lo} : shifted;
          q     <= {q[30:0], no_borrow};
          count <= count + 5'd1;
          if (count == 5'd31) begin
            state <= FIX;
          end
        end

        FIX: begin
          quotient    <= sign_q ? (~q + 32'd1) : q;
          remainder   <= sign_r ? (~r + 32'd1) : r;
          div_by_zero <= 1'b0;
          state       <= DONE;
          busy        <= 1'b0;
          ready       <= 1'b1;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div32_iter.sv
module tb_div32_iter;

  logic        clk;
  logic        resetn;
  logic        start;
  logic        signed_div;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        annul;
  logic        busy;
  logic        ready;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  div32_iter dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .signed_div  (signed_div),
    .dividend    (dividend),
    .divisor     (divisor),
    .annul       (annul),
    .busy        (busy),
    .ready       (ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // monitor: pops the scoreboard on every ready pulse
  always @(negedge clk) begin
    if (ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ready_cycle", cyc, e.cyc);
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
      end
    end
  end

  // called just after a rising edge; the current cycle is the start cycle
  task automatic issue(input logic sd, input logic [31:0] a, input logic [31:0] b,
                       input bit expect_result, input logic [31:0] eq,
                       input logic [31:0] er, input logic edz, input int lat);
    exp_t e;
    signed_div = sd;
    dividend   = a;
    divisor    = b;
    start      = 1'b1;
    if (expect_result) begin
      e.q = eq; e.r = er; e.dz = edz; e.cyc = cyc + lat;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL wait_result actual=pending expected=drained (cycle %0d)", cyc);
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic to_cycle(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    resetn = 1'b0; start = 1'b0; signed_div = 1'b0;
    dividend = 32'd0; divisor = 32'd0; annul = 1'b0;
    #12;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_ready", {31'd0, ready}, 32'd0);
    chk("reset_quotient", quotient, 32'd0);
    chk("reset_remainder", remainder, 32'd0);
    chk("reset_dz", {31'd0, div_by_zero}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // unsigned basic with busy window
    s = cyc;
    issue(1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0, 34);
    for (int i = 1; i <= 34; i++) begin
      @(negedge clk);
      chk($sformatf("busy_c%0d", i), {31'd0, busy}, (i <= 33) ? 32'd1 : 32'd0);
    end
    @(posedge clk); #1;
    wait_empty();

    // back-to-back: start in the DONE cycle, then signed cases
    s = cyc;
    issue(1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0, 34);
    to_cycle(s + 34);
    issue(1'b1, 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 34);
    wait_empty();
    issue(1'b1, 32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1, 1'b0, 34);
    wait_empty();
    issue(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 1'b0, 34);
    wait_empty();
    issue(1'b0, 32'hFFFFFFFF, 32'd1, 1'b1, 32'hFFFFFFFF, 32'd0, 1'b0, 34);
    wait_empty();
    issue(1'b0, 32'd1000, 32'd7, 1'b1, 32'd142, 32'd6, 1'b0, 34);
    wait_empty();

    // divide by zero, then a start in its DONE cycle
    issue(1'b0, 32'h1234, 32'd0, 1'b1, 32'd0, 32'h1234, 1'b1, 1);
    issue(1'b0, 32'd100, 32'd7, 1'b1, 32'd14, 32'd2, 1'b0, 34);
    wait_empty();
    issue(1'b1, 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 34);
    wait_empty();

    // annul in cycle 10; outputs keep -7/2 result; restart in cycle 12
    s = cyc;
    issue(1'b0, 32'd1000, 32'd3, 1'b0, 32'd0, 32'd0, 1'b0, 0);
    to_cycle(s + 10);
    annul = 1'b1;
    @(posedge clk); #1;
    annul = 1'b0;
    @(negedge clk);
    chk("annul_busy", {31'd0, busy}, 32'd0);
    chk("annul_hold_q", quotient, 32'hFFFFFFFD);
    chk("annul_hold_r", remainder, 32'hFFFFFFFF);
    to_cycle(s + 12);
    issue(1'b0, 32'd9, 32'd3, 1'b1, 32'd3, 32'd0, 1'b0, 34);
    wait_empty();

    // start together with annul is ignored
    signed_div = 1'b0; dividend = 32'd50; divisor = 32'd5;
    start = 1'b1; annul = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; annul = 1'b0;
    @(negedge clk);
    chk("start_annul_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;

    // start during CALC is ignored
    s = cyc;
    issue(1'b0, 32'd1000, 32'd7, 1'b1, 32'd142, 32'd6, 1'b0, 34);
    to_cycle(s + 5);
    issue(1'b0, 32'd5, 32'd1, 1'b0, 32'd0, 32'd0, 1'b0, 0);
    wait_empty();

    // reset mid-operation
    s = cyc;
    issue(1'b0, 32'd100, 32'd7, 1'b0, 32'd0, 32'd0, 1'b0, 0);
    to_cycle(s + 20);
    resetn = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_ready", {31'd0, ready}, 32'd0);
    chk("midrst_quotient", quotient, 32'd0);
    chk("midrst_remainder", remainder, 32'd0);
    chk("midrst_dz", {31'd0, div_by_zero}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (30) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
